// File: rtl/cpu_pkg.sv
// Shared widths, opcodes and FSM states for the execute unit.
// Optional multiplier is controlled by EXEC_UNIT_MUL_EN.
package cpu_pkg;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int OW = 3;

  localparam logic [OW-1:0] OP_ADD = 3'd0;
  localparam logic [OW-1:0] OP_SUB = 3'd1;
  localparam logic [OW-1:0] OP_AND = 3'd2;
  localparam logic [OW-1:0] OP_OR  = 3'd3;
  localparam logic [OW-1:0] OP_XOR = 3'd4;
  localparam logic [OW-1:0] OP_SHL = 3'd5;
  localparam logic [OW-1:0] OP_MOV = 3'd6;
  localparam logic [OW-1:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_WB
  } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational result and carry for the single-cycle opcodes.
// Opcode 7 is handled by the multiplier in exec_unit.
module exec_alu
  import cpu_pkg::*;
(
  input  logic [OW-1:0] op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] t;

  always_comb begin
    t      = '0;
    result = '0;
    carry  = 1'b0;
    unique case (1'b1)
      op == OP_ADD: begin
        t      = {1'b0, a} + {1'b0, b};
        result = t[DW-1:0];
        carry  = t[DW];
      end
      op == OP_SUB: begin
        t      = {1'b0, a} - {1'b0, b};
        result = t[DW-1:0];
        carry  = t[DW];
      end
      op == OP_AND: result = a & b;
      op == OP_OR:  result = a | b;
      op == OP_XOR: result = a ^ b;
      op == OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        carry  = a[DW-1];
      end
      op == OP_MOV: result = a;
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Execute unit: IDLE/MUL/WB FSM with register-file write-back.
// Define EXEC_UNIT_MUL_EN to build the shift-add multiplier (opcode 7).
module exec_unit
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [OW-1:0] instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  output logic [AW-1:0] rf_read_addr1,
  output logic [AW-1:0] rf_read_addr2,
  input  logic [DW-1:0] rf_read_data1,
  input  logic [DW-1:0] rf_read_data2,
  output logic          rf_write_en,
  output logic [AW-1:0] rf_write_addr,
  output logic [DW-1:0] rf_write_data,
  output logic          busy,
  output logic          flag_c,
  output logic          flag_z,
  output logic          illegal_op
);

  state_t        state;
  logic [OW-1:0] op_q;
  logic [AW-1:0] rd_q, rs1_q, rs2_q;
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic [DW-1:0] wr_data;
  logic          wr_c;
  logic          accept;

  assign instr_ready   = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign accept        = instr_valid && instr_ready;
  assign rf_read_addr1 = instr_ready ? instr_rs1 : rs1_q;
  assign rf_read_addr2 = instr_ready ? instr_rs2 : rs2_q;
  assign rf_write_addr = rd_q;
  assign rf_write_data = wr_data;

  exec_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .carry  (alu_c)
  );

`ifdef EXEC_UNIT_MUL_EN
  logic [2*DW-1:0] acc, mcand, acc_nx;
  logic [2:0]      cnt;

  // b_q doubles as the multiplier shift register, consumed LSB first
  assign acc_nx = acc + (b_q[0] ? mcand : '0);

  always_comb begin
    wr_data = alu_res;
    wr_c    = alu_c;
    if (op_q == OP_MUL) begin
      wr_data = acc[DW-1:0];
      wr_c    = |acc[2*DW-1:DW];
    end
  end
`else
  always_comb begin
    wr_data = alu_res;
    wr_c    = alu_c;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rf_write_en <= 1'b0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      illegal_op  <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
      acc         <= '0;
      mcand       <= '0;
      cnt         <= '0;
`endif
    end else begin
      illegal_op  <= 1'b0;
      rf_write_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            a_q   <= rf_read_data1;
            b_q   <= rf_read_data2;
            if (instr_op == OP_MUL) begin
`ifdef EXEC_UNIT_MUL_EN
              acc   <= '0;
              mcand <= {{DW{1'b0}}, rf_read_data1};
              cnt   <= '0;
              state <= S_MUL;
`else
              illegal_op <= 1'b1;
`endif
            end else begin
              rf_write_en <= 1'b1;
              state       <= S_WB;
            end
          end
        end
        S_MUL: begin
`ifdef EXEC_UNIT_MUL_EN
          acc   <= acc_nx;
          mcand <= mcand << 1;
          b_q   <= b_q >> 1;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            rf_write_en <= 1'b1;
            state       <= S_WB;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_WB: begin
          flag_c <= wr_c;
          flag_z <= (wr_data == '0);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit with a behavioural register file.
// Covers MUL when built with EXEC_UNIT_MUL_EN, illegal opcode otherwise.
module tb_exec_unit;
  import cpu_pkg::*;

`ifdef EXEC_UNIT_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [2:0] instr_rd = '0;
  logic [2:0] instr_rs1 = '0;
  logic [2:0] instr_rs2 = '0;
  logic [2:0] rf_read_addr1, rf_read_addr2;
  logic [7:0] rf_read_data1, rf_read_data2;
  logic       rf_write_en;
  logic [2:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic       busy, flag_c, flag_z, illegal_op;

  logic [7:0] rf [8];
  logic       pl_en = 1'b0;
  logic [2:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] d;
    logic       c;
    int         due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  exec_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rd      (instr_rd),
    .instr_rs1     (instr_rs1),
    .instr_rs2     (instr_rs2),
    .rf_read_addr1 (rf_read_addr1),
    .rf_read_addr2 (rf_read_addr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .busy          (busy),
    .flag_c        (flag_c),
    .flag_z        (flag_z),
    .illegal_op    (illegal_op)
  );

  assign rf_read_data1 = rf[rf_read_addr1];
  assign rf_read_data2 = rf[rf_read_addr2];

  always @(posedge clk) begin
    if (rf_write_en) rf[rf_write_addr] <= rf_write_data;
    if (pl_en) rf[pl_addr] <= pl_data;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input int op, input int a,
                                       input int b);
    int r;
    bit c;
    r = 0;
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * 2; c = (a >= 128); end
      6: r = a;
      default: begin r = a * b; c = (r > 255); end
    endcase
    r = r & 255;
    return {c, r[7:0]};
  endfunction

  // write-back monitor; flags are due one cycle after the write
  logic fl_pend = 1'b0;
  logic efc, efz;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (fl_pend) begin
        chk("flag_c", flag_c, efc);
        chk("flag_z", flag_z, efz);
        fl_pend = 1'b0;
      end
      if (rf_write_en) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", rf_write_addr, e.rd);
          chk("wr_data", rf_write_data, e.d);
          chk("wr_cycle", cyc, e.due);
          efc = e.c;
          efz = (e.d == 8'h00);
          fl_pend = 1'b1;
        end
      end
    end
  end

  task automatic set_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2);
    int n;
    logic [8:0] m;
    exp_t e;
    n = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op;
    instr_rd = rd;
    instr_rs1 = rs1;
    instr_rs2 = rs2;
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", n < 40, 1);
    m = model(int'(op), int'(rf[rs1]), int'(rf[rs2]));
    @(posedge clk);
    #1 instr_valid = 1'b0;
    if (op != 3'd7 || MUL_EN) begin
      e.rd = rd;
      e.d = m[7:0];
      e.c = m[8];
      e.due = cyc + ((op == 3'd7) ? 9 : 1) - 1;
      sb.push_back(e);
    end
  endtask

  task automatic reset_abort(input logic [2:0] rd, input logic [7:0] old);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_wen", rf_write_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", flag_c, 0);
    chk("rst_fz", flag_z, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_nowr", rf[rd], old);
  endtask

  initial begin
    int c0;
    logic [2:0] rop;
    repeat (2) @(negedge clk);
    chk("r_ready", instr_ready, 1);
    chk("r_busy", busy, 0);
    chk("r_wen", rf_write_en, 0);
    chk("r_ill", illegal_op, 0);
    chk("r_fc", flag_c, 0);
    chk("r_fz", flag_z, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) set_reg(3'(i), 8'(i * 8'h11));

    set_reg(3'd1, 8'hF0);
    set_reg(3'd2, 8'h20);
    issue(3'd0, 3'd3, 3'd1, 3'd2);
    chk("wb_busy", busy, 1);
    chk("wb_ready", instr_ready, 0);

    set_reg(3'd5, 8'h05);
    set_reg(3'd6, 8'h05);
    set_reg(3'd7, 8'h03);
    issue(3'd1, 3'd4, 3'd5, 3'd6);
    issue(3'd1, 3'd4, 3'd7, 3'd5);
    issue(3'd2, 3'd0, 3'd1, 3'd7);
    issue(3'd3, 3'd0, 3'd2, 3'd7);
    issue(3'd4, 3'd0, 3'd1, 3'd1);
    issue(3'd5, 3'd6, 3'd1, 3'd0);
    issue(3'd6, 3'd6, 3'd7, 3'd0);

    issue(3'd0, 3'd1, 3'd1, 3'd2);
    c0 = cyc;
    issue(3'd6, 3'd4, 3'd1, 3'd0);
    chk("b2b_cycle", cyc, c0 + 2);

    if (MUL_EN) begin
      set_reg(3'd1, 8'h12);
      set_reg(3'd2, 8'h10);
      issue(3'd7, 3'd3, 3'd1, 3'd2);
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        chk("mul_busy", busy, 1);
      end
      issue(3'd7, 3'd5, 3'd1, 3'd2);
      repeat (4) @(negedge clk);
      reset_abort(3'd5, rf[5]);
    end else begin
      set_reg(3'd5, 8'h05);
      issue(3'd1, 3'd0, 3'd5, 3'd5);
      issue(3'd7, 3'd3, 3'd1, 3'd2);
      @(negedge clk);
      chk("ill_pulse", illegal_op, 1);
      chk("ill_wen", rf_write_en, 0);
      chk("ill_ready", instr_ready, 1);
      @(negedge clk);
      chk("ill_end", illegal_op, 0);
      chk("ill_fz", flag_z, 1);
      chk("ill_fc", flag_c, 0);
    end

    issue(3'd0, 3'd2, 3'd1, 3'd1);
    reset_abort(3'd2, rf[2]);

    for (int i = 0; i < 8; i++) set_reg(3'(i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 24; i++) begin
      rop = MUL_EN ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
      issue(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
    end

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
